// File: rtl/abc_sum_square.sv
// Sequencer for two A/D converters sharing one start line: converts x and y,
// then hands q = (x+y)^2 to a consumer over an active-low dav_/rfd handshake.
module abc_sum_square (
  input  logic        clock,
  input  logic        reset_,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        eocx,
  input  logic        eocy,
  input  logic        rfd,
  output logic        soc,
  output logic [31:0] q,
  output logic        dav_,
  output logic [2:0]  state_dbg_o
);

  // Handshake: dav_ falls only after q has been stable for a clock; the
  // consumer must complete rfd 1->0->1 before the next conversion starts.
  typedef enum logic [2:0] {
    S0_WAIT_IDLE    = 3'd0,
    S1_START        = 3'd1,
    S2_WAIT_DATA    = 3'd2,
    S3_READY_WAIT   = 3'd3,
    S4_OUT          = 3'd4,
    S5_WAIT_ACK_END = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        soc_q, soc_d;
  logic        dav_q, dav_d;
  logic [17:0] sq_q, sq_d;
  logic [8:0]  sum;
  logic [17:0] square;

  assign sum    = {1'b0, x} + {1'b0, y};
  assign square = {9'b0, sum} * {9'b0, sum};

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S0_WAIT_IDLE;
      soc_q   <= 1'b0;
      dav_q   <= 1'b1;
      sq_q    <= 18'd0;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      dav_q   <= dav_d;
      sq_q    <= sq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    soc_d   = soc_q;
    dav_d   = dav_q;
    sq_d    = sq_q;
    case (state_q)
      S0_WAIT_IDLE: begin
        if (eocx && eocy) begin
          soc_d   = 1'b1;
          state_d = S1_START;
        end
      end
      S1_START: begin
        // Converters may acknowledge on different cycles; hold soc for both.
        if (!eocx && !eocy) begin
          soc_d   = 1'b0;
          state_d = S2_WAIT_DATA;
        end
      end
      S2_WAIT_DATA: begin
        if (eocx && eocy) begin
          sq_d    = square;
          state_d = S3_READY_WAIT;
        end
      end
      S3_READY_WAIT: begin
        if (rfd) begin
          dav_d   = 1'b0;
          state_d = S4_OUT;
        end
      end
      S4_OUT: begin
        if (!rfd) begin
          dav_d   = 1'b1;
          state_d = S5_WAIT_ACK_END;
        end
      end
      S5_WAIT_ACK_END: begin
        if (rfd) state_d = S0_WAIT_IDLE;
      end
      default: begin
        state_d = S0_WAIT_IDLE;
        soc_d   = 1'b0;
        dav_d   = 1'b1;
      end
    endcase
  end

  assign soc         = soc_q;
  assign dav_        = dav_q;
  assign q           = {14'd0, sq_q};
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_abc_sum_square.sv
// Directed bench for abc_sum_square: inputs driven and outputs sampled on the
// falling clock edge; expected results are hand-computed constants.
module tb_abc_sum_square;

  logic        clock;
  logic        reset_;
  logic [7:0]  x, y;
  logic        eocx, eocy, rfd;
  logic        soc, dav_;
  logic [31:0] q;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  abc_sum_square dut (
    .clock       (clock),
    .reset_      (reset_),
    .x           (x),
    .y           (y),
    .eocx        (eocx),
    .eocy        (eocy),
    .rfd         (rfd),
    .soc         (soc),
    .q           (q),
    .dav_        (dav_),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Bounded wait for soc to rise; an expired budget shows as a failed check.
  task automatic wait_soc(input string tag);
    int n;
    n = 0;
    while (soc !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_eq(tag, {31'd0, soc}, 32'd1);
  endtask

  // One transaction with immediately responding converters and consumer.
  task automatic run_txn(input logic [7:0] xv, input logic [7:0] yv, input logic [31:0] exp_q);
    wait_soc("soc_rise");
    eocx = 1'b0; eocy = 1'b0;
    step();
    check_eq("soc_fall", {31'd0, soc}, 32'd0);
    x = xv; y = yv; eocx = 1'b1; eocy = 1'b1;
    step();
    check_eq("q_before_dav", q, exp_q);
    check_eq("dav_still_high", {31'd0, dav_}, 32'd1);
    step();
    check_eq("dav_low", {31'd0, dav_}, 32'd0);
    check_eq("q_at_dav_fall", q, exp_q);
    rfd = 1'b0;
    step();
    check_eq("dav_rise", {31'd0, dav_}, 32'd1);
    check_eq("soc_idle", {31'd0, soc}, 32'd0);
    rfd = 1'b1;
    step();
    check_eq("back_to_s0", {29'd0, state_dbg}, 32'd0);
  endtask

  logic [7:0]  sw_x [15] = '{8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1,
                             8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0]  sw_y [15] = '{8'd4, 8'd4, 8'd4, 8'd5, 8'd5, 8'd5, 8'd5, 8'd6,
                             8'd6, 8'd6, 8'd6, 8'd7, 8'd7, 8'd7, 8'd7};
  logic [31:0] sw_q [15] = '{32'd36, 32'd49, 32'd64, 32'd36, 32'd49, 32'd64, 32'd81, 32'd49,
                             32'd64, 32'd81, 32'd100, 32'd64, 32'd81, 32'd100, 32'd121};

  initial begin
    reset_ = 1'b0; x = 8'd0; y = 8'd0; eocx = 1'b1; eocy = 1'b1; rfd = 1'b1;

    // Reset state
    repeat (3) step();
    check_eq("rst_soc", {31'd0, soc}, 32'd0);
    check_eq("rst_dav", {31'd0, dav_}, 32'd1);
    check_eq("rst_q", q, 32'd0);
    check_eq("rst_state", {29'd0, state_dbg}, 32'd0);
    reset_ = 1'b1;
    step();
    check_eq("soc_after_release", {31'd0, soc}, 32'd1);

    // Maximum operands
    run_txn(8'hFF, 8'hFF, 32'd260100);

    // Sweep
    for (int i = 0; i < 15; i++) run_txn(sw_x[i], sw_y[i], sw_q[i]);

    // A few asymmetric operands
    run_txn(8'hFF, 8'h00, 32'd65025);
    run_txn(8'd200, 8'd100, 32'd90000);
    run_txn(8'd0, 8'd0, 32'd0);
    run_txn(8'd0, 8'd9, 32'd81);

    // Skewed eoc: X acknowledges 3 clocks before Y, and finishes 2 clocks earlier
    wait_soc("skew_soc_rise");
    eocx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("skew_soc_held", {31'd0, soc}, 32'd1);
    end
    eocy = 1'b0;
    step();
    check_eq("skew_soc_fall", {31'd0, soc}, 32'd0);
    x = 8'd10; y = 8'd55; eocx = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("skew_q_unchanged", q, 32'd81);
      check_eq("skew_wait_data", {29'd0, state_dbg}, 32'd2);
    end
    y = 8'd20; eocy = 1'b1;
    step();
    check_eq("skew_q_sampled", q, 32'd900);
    step();
    check_eq("skew_dav_low", {31'd0, dav_}, 32'd0);
    rfd = 1'b0;
    step();
    rfd = 1'b1;
    step();

    // Consumer stall before, during and after dav_
    wait_soc("stall_soc_rise");
    eocx = 1'b0; eocy = 1'b0;
    step();
    x = 8'd7; y = 8'd8; eocx = 1'b1; eocy = 1'b1; rfd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_dav_high", {31'd0, dav_}, 32'd1);
    end
    check_eq("stall_q", q, 32'd225);
    rfd = 1'b1;
    step();
    check_eq("stall_dav_low", {31'd0, dav_}, 32'd0);
    x = 8'd1; y = 8'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_dav_low", {31'd0, dav_}, 32'd0);
      check_eq("hold_q_stable", q, 32'd225);
      check_eq("hold_no_soc", {31'd0, soc}, 32'd0);
    end
    rfd = 1'b0;
    step();
    check_eq("stall_dav_rise", {31'd0, dav_}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ack_soc_low", {31'd0, soc}, 32'd0);
    end
    rfd = 1'b1;
    step();
    check_eq("ack_end_soc_low", {31'd0, soc}, 32'd0);
    step();
    check_eq("ack_end_soc_rise", {31'd0, soc}, 32'd1);

    // Async reset while dav_ is low
    eocx = 1'b0; eocy = 1'b0;
    step();
    x = 8'd3; y = 8'd3; eocx = 1'b1; eocy = 1'b1;
    step();
    step();
    check_eq("pre_areset_dav", {31'd0, dav_}, 32'd0);
    check_eq("pre_areset_q", q, 32'd36);
    #2 reset_ = 1'b0;
    #1;
    check_eq("areset_dav", {31'd0, dav_}, 32'd1);
    check_eq("areset_soc", {31'd0, soc}, 32'd0);
    check_eq("areset_q", q, 32'd0);
    check_eq("areset_state", {29'd0, state_dbg}, 32'd0);
    step();
    reset_ = 1'b1;
    step();
    check_eq("restart_soc", {31'd0, soc}, 32'd1);
    run_txn(8'd5, 8'd6, 32'd121);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
